// File: rtl/vram_pkg.sv
// Shared constants, types and FSM encoding for the VRAM rectangle-fill engine.
package vram_pkg;

   localparam int VRAM_COORD_W = 7;
   localparam int VRAM_COLOR_W = 4;
   localparam int VRAM_DIM     = 128;

   typedef logic [2*VRAM_COORD_W-1:0] vram_addr_t;
   typedef logic [VRAM_COLOR_W-1:0]   vram_color_t;
   typedef logic [VRAM_COORD_W-1:0]   vram_coord_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_t;

endpackage : vram_pkg

// File: rtl/vram_rect_fill_if.sv
// Command handshake, write-grant and VRAM write-port bundle of the fill engine.
// Signal names keep their direction prefix as seen from the engine.
interface vram_rect_fill_if
   import vram_pkg::*;
#(
   parameter int COORD_W = VRAM_COORD_W,
   parameter int COLOR_W = VRAM_COLOR_W
) ();

   logic                   i_Cmd_Valid;
   logic                   o_Cmd_Ready;
   logic [COORD_W-1:0]     i_Cmd_X;
   logic [COORD_W-1:0]     i_Cmd_Y;
   logic [COORD_W:0]       i_Cmd_W;
   logic [COORD_W:0]       i_Cmd_H;
   logic [COLOR_W-1:0]     i_Cmd_Color;
   logic                   i_Grant;
   logic [2*COORD_W-1:0]   o_Vram_Addr;
   logic [COLOR_W-1:0]     o_Vram_Din;
   logic                   o_Vram_We;
   logic                   o_Busy;
   logic                   o_Done;

   // Command source and write arbiter side
   modport master (
      output i_Cmd_Valid, i_Cmd_X, i_Cmd_Y, i_Cmd_W, i_Cmd_H, i_Cmd_Color, i_Grant,
      input  o_Cmd_Ready, o_Vram_Addr, o_Vram_Din, o_Vram_We, o_Busy, o_Done
   );

   // Fill engine side
   modport slave (
      input  i_Cmd_Valid, i_Cmd_X, i_Cmd_Y, i_Cmd_W, i_Cmd_H, i_Cmd_Color, i_Grant,
      output o_Cmd_Ready, o_Vram_Addr, o_Vram_Din, o_Vram_We, o_Busy, o_Done
   );

endinterface : vram_rect_fill_if

// File: rtl/vram_rect_walker.sv
// Row-major pixel walker: column/row counter pair that reloads the column
// from the rectangle origin at the end of each row and flags the last pixel.
// The counters freeze on the last pixel so they never step past the clip edge.
module vram_rect_walker
   import vram_pkg::*;
#(
   parameter int COORD_W = VRAM_COORD_W
) (
   input  logic               i_Clk,
   input  logic               i_Reset,
   input  logic               i_Load,
   input  logic               i_Step,
   input  logic [COORD_W-1:0] i_X,
   input  logic [COORD_W-1:0] i_Y,
   input  logic [COORD_W-1:0] i_X_End,
   input  logic [COORD_W-1:0] i_Y_End,
   output logic [COORD_W-1:0] o_Col,
   output logic [COORD_W-1:0] o_Row,
   output logic               o_Last
);

   logic [COORD_W-1:0] col_q, col_d;
   logic [COORD_W-1:0] row_q, row_d;
   logic [COORD_W-1:0] x_org_q, x_org_d;
   logic [COORD_W-1:0] x_end_q, x_end_d;
   logic [COORD_W-1:0] y_end_q, y_end_d;
   logic               last_s;

   assign last_s = (col_q == x_end_q) && (row_q == y_end_q);

   // Next-state: load a new rectangle, or advance one pixel on a granted write
   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      x_org_d = x_org_q;
      x_end_d = x_end_q;
      y_end_d = y_end_q;
      if (i_Load) begin
         col_d   = i_X;
         row_d   = i_Y;
         x_org_d = i_X;
         x_end_d = i_X_End;
         y_end_d = i_Y_End;
      end else if (i_Step && !last_s) begin
         if (col_q == x_end_q) begin
            col_d = x_org_q;
            row_d = row_q + {{(COORD_W-1){1'b0}}, 1'b1};
         end else begin
            col_d = col_q + {{(COORD_W-1){1'b0}}, 1'b1};
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // Counter and bound registers
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         col_q   <= '0;
         row_q   <= '0;
         x_org_q <= '0;
         x_end_q <= '0;
         y_end_q <= '0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         x_org_q <= x_org_d;
         x_end_q <= x_end_d;
         y_end_q <= y_end_d;
      end
   end

   assign o_Col  = col_q;
   assign o_Row  = row_q;
   assign o_Last = last_s;

endmodule : vram_rect_walker

// File: rtl/vram_rect_fill.sv
// Rectangle-fill write engine for the 128x128x4 video RAM. Accepts a fill
// command, clips it to the frame and issues one VRAM write per granted cycle
// in row-major order, then pulses o_Done.
module vram_rect_fill
   import vram_pkg::*;
#(
   parameter int COORD_W = VRAM_COORD_W,
   parameter int COLOR_W = VRAM_COLOR_W
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   vram_rect_fill_if.slave   bus
);

   localparam int                 SUM_W     = COORD_W + 2;
   localparam logic [SUM_W-1:0]   COORD_MAX = SUM_W'((1 << COORD_W) - 1);

   fill_state_t         state_q;
   logic [COLOR_W-1:0]  color_q;
   logic                ready_q;
   logic                busy_q;
   logic                done_q;

   logic [SUM_W-1:0]    x_sum_s;
   logic [SUM_W-1:0]    y_sum_s;
   logic [COORD_W-1:0]  x_end_s;
   logic [COORD_W-1:0]  y_end_s;
   logic                accept_s;
   logic                empty_s;
   logic                step_s;
   logic                last_s;
   logic [COORD_W-1:0]  col_s;
   logic [COORD_W-1:0]  row_s;

   assign accept_s = bus.i_Cmd_Valid && (state_q == ST_IDLE);
   assign empty_s  = (bus.i_Cmd_W == '0) || (bus.i_Cmd_H == '0);
   assign step_s   = (state_q == ST_FILL) && bus.i_Grant;

   // Inclusive end coordinates, clipped to the frame edge; wide sums cannot overflow
   always_comb begin
      x_sum_s = {2'b00, bus.i_Cmd_X} + {1'b0, bus.i_Cmd_W} - SUM_W'(1);
      y_sum_s = {2'b00, bus.i_Cmd_Y} + {1'b0, bus.i_Cmd_H} - SUM_W'(1);
      if (x_sum_s > COORD_MAX) begin
         x_end_s = COORD_MAX[COORD_W-1:0];
      end else begin
         x_end_s = x_sum_s[COORD_W-1:0];
      end
      if (y_sum_s > COORD_MAX) begin
         y_end_s = COORD_MAX[COORD_W-1:0];
      end else begin
         y_end_s = y_sum_s[COORD_W-1:0];
      end
   end

   vram_rect_walker #(
      .COORD_W (COORD_W)
   ) u_walker (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_Load  (accept_s && !empty_s),
      .i_Step  (step_s),
      .i_X     (bus.i_Cmd_X),
      .i_Y     (bus.i_Cmd_Y),
      .i_X_End (x_end_s),
      .i_Y_End (y_end_s),
      .o_Col   (col_s),
      .o_Row   (row_s),
      .o_Last  (last_s)
   );

   // Fill sequencer with registered ready/busy/done flags
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q <= ST_IDLE;
         color_q <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (accept_s) begin
                  color_q <= bus.i_Cmd_Color;
                  ready_q <= 1'b0;
                  if (empty_s) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_FILL;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            ST_FILL: begin
               if (step_s && last_s) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_Cmd_Ready = ready_q;
   assign bus.o_Busy      = busy_q;
   assign bus.o_Done      = done_q;
   assign bus.o_Vram_We   = step_s;
   assign bus.o_Vram_Addr = {row_s, col_s};
   assign bus.o_Vram_Din  = color_q;

endmodule : vram_rect_fill

// File: tb/tb_vram_rect_fill.sv
// Self-checking bench for vram_rect_fill: directed and random fill commands
// under several grant patterns, scored against a pixel-list model.
module tb_vram_rect_fill;
   import vram_pkg::*;

   logic clk;
   logic rst;

   vram_rect_fill_if bus ();

   vram_rect_fill dut (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int gpat [7] = '{1, 0, 0, 1, 0, 1, 1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic pick_grant(input int gmode, input int k);
      if (gmode == 0) return 1'b1;
      if (gmode == 1) return 1'($urandom_range(0, 1));
      if (k <= 7) return gpat[k-1] != 0;
      return 1'b1;
   endfunction

   task automatic scramble_cmd();
      bus.i_Cmd_X     = 7'($urandom);
      bus.i_Cmd_Y     = 7'($urandom);
      bus.i_Cmd_W     = 8'($urandom);
      bus.i_Cmd_H     = 8'($urandom);
      bus.i_Cmd_Color = 4'($urandom);
   endtask

   // Issue one command and score every cycle until its done pulse.
   task automatic run_cmd(input int x, input int y, input int w, input int h,
                          input int c, input int gmode);
      int q[$];
      int xe, ye, n, written, done_k, k, bound;
      bit finished, exp_we, exp_busy;
      xe = x + w - 1; if (xe > VRAM_DIM - 1) xe = VRAM_DIM - 1;
      ye = y + h - 1; if (ye > VRAM_DIM - 1) ye = VRAM_DIM - 1;
      if (w > 0 && h > 0)
         for (int r = y; r <= ye; r++)
            for (int cc = x; cc <= xe; cc++)
               q.push_back(r * VRAM_DIM + cc);
      n = q.size();
      bound = (gmode == 1) ? 4 * n + 64 : n + 16;

      bus.i_Cmd_X     = 7'(x);
      bus.i_Cmd_Y     = 7'(y);
      bus.i_Cmd_W     = 8'(w);
      bus.i_Cmd_H     = 8'(h);
      bus.i_Cmd_Color = 4'(c);
      bus.i_Cmd_Valid = 1'b1;
      bus.i_Grant     = 1'($urandom_range(0, 1));
      #1;
      check_eq("cmd_ready", bus.o_Cmd_Ready, 1);
      check_eq("idle_we", bus.o_Vram_We, 0);
      @(posedge clk); #1;

      written  = 0;
      done_k   = (n == 0) ? 1 : -1;
      k        = 1;
      finished = 0;
      while (!finished) begin
         bus.i_Grant     = pick_grant(gmode, k);
         bus.i_Cmd_Valid = 1'($urandom_range(0, 1));
         scramble_cmd();
         #1;
         exp_we   = bus.i_Grant && (written < n);
         exp_busy = (n > 0) && (done_k < 0 || k < done_k);
         check_eq("we", bus.o_Vram_We, exp_we);
         if (exp_we && bus.o_Vram_We) begin
            check_eq("addr", bus.o_Vram_Addr, q[written]);
            check_eq("din", bus.o_Vram_Din, c);
         end
         check_eq("done", bus.o_Done, (k == done_k));
         check_eq("busy", bus.o_Busy, exp_busy);
         check_eq("ready_low", bus.o_Cmd_Ready, 0);
         if (exp_we) begin
            written++;
            if (written == n) done_k = k + 1;
         end
         if (k == done_k) finished = 1;
         else if (k > bound) begin
            check_eq("fill_timeout", k, done_k);
            finished = 1;
         end
         @(posedge clk); #1;
         k++;
      end

      bus.i_Cmd_Valid = 1'b0;
      bus.i_Grant     = 1'($urandom_range(0, 1));
      #1;
      check_eq("ready_back", bus.o_Cmd_Ready, 1);
      check_eq("done_once", bus.o_Done, 0);
      check_eq("post_we", bus.o_Vram_We, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int rx, ry, rw, rh;
      rst             = 1'b1;
      bus.i_Cmd_Valid = 1'b0;
      bus.i_Grant     = 1'b1;
      scramble_cmd();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", bus.o_Cmd_Ready, 1);
      check_eq("rst_we", bus.o_Vram_We, 0);
      check_eq("rst_addr", bus.o_Vram_Addr, 0);
      check_eq("rst_din", bus.o_Vram_Din, 0);
      check_eq("rst_busy", bus.o_Busy, 0);
      check_eq("rst_done", bus.o_Done, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      run_cmd(2, 3, 3, 2, 'hA, 0);
      run_cmd(126, 127, 10, 10, 'h5, 0);
      run_cmd(40, 50, 0, 7, 'h3, 0);
      run_cmd(40, 50, 7, 0, 'hC, 0);
      run_cmd(10, 20, 2, 2, 'h7, 2);
      run_cmd(127, 0, 128, 1, 'h1, 1);

      // Reset during the third cycle of a 4x4 fill
      bus.i_Cmd_X = 7'd10; bus.i_Cmd_Y = 7'd20;
      bus.i_Cmd_W = 8'd4;  bus.i_Cmd_H = 8'd4;
      bus.i_Cmd_Color = 4'h9; bus.i_Cmd_Valid = 1'b1; bus.i_Grant = 1'b1;
      @(posedge clk); #1;
      bus.i_Cmd_Valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (k == 3) rst = 1'b1;
         #1;
         check_eq("abort_pre_we", bus.o_Vram_We, 1);
         check_eq("abort_pre_addr", bus.o_Vram_Addr, 20 * VRAM_DIM + 10 + k - 1);
         @(posedge clk); #1;
      end
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("abort_we", bus.o_Vram_We, 0);
         check_eq("abort_done", bus.o_Done, 0);
         check_eq("abort_ready", bus.o_Cmd_Ready, 1);
         check_eq("abort_busy", bus.o_Busy, 0);
         @(posedge clk); #1;
      end
      run_cmd(5, 6, 1, 1, 'hE, 0);

      // Random commands, many straddling the frame edge
      for (int i = 0; i < 16; i++) begin
         rx = $urandom_range(0, 127);
         ry = $urandom_range(0, 127);
         rw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 128) : $urandom_range(0, 12);
         rh = $urandom_range(0, 12);
         run_cmd(rx, ry, rw, rh, $urandom_range(0, 15), $urandom_range(0, 1));
      end

      // Whole frame, continuous grant
      run_cmd(0, 0, 128, 128, 'h6, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_vram_rect_fill
